// File: rtl/uart_pattern_tx.sv
// UART transmitter with a built-in payload source (counter, fixed, LFSR or stream).
// Single clock domain: bit timing and frame pacing come from clock-enable counters.
module uart_pattern_tx #(
    parameter int BAUD_DIV  = 625,
    parameter int INTERVAL  = 20000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DATA_BITS-1:0] pattern,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 overrun
);

    localparam int          BAUD_W     = $clog2(BAUD_DIV);
    localparam int          IVAL_W     = $clog2(INTERVAL + 1);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [1:0]  MODE_COUNT = 2'b00;
    localparam logic [1:0]  MODE_FIXED = 2'b01;
    localparam logic [1:0]  MODE_LFSR  = 2'b10;
    localparam logic [1:0]  MODE_STRM  = 2'b11;
    localparam bit          HAS_PARITY = (PARITY != 0);
    localparam logic [3:0]  LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        parity_of = (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t                 state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [3:0]             bit_cnt;
    logic [IVAL_W-1:0]      ival_cnt;
    logic [DATA_BITS-1:0]   count_val;
    logic [15:0]            lfsr;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [DATA_BITS-1:0]   payload;
    logic                   baud_tc;
    logic                   ival_tc;
    logic                   paced_tick;
    logic                   stream_xfer;
    logic                   start_frame;
    logic                   is_idle;

    assign is_idle     = (state == S_IDLE);
    assign baud_tc     = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign ival_tc     = (ival_cnt == IVAL_W'(INTERVAL - 1));
    assign paced_tick  = enable & (mode != MODE_STRM) & ival_tc;
    // reset term keeps in_ready low while the block is held in reset
    assign in_ready    = reset & enable & (mode == MODE_STRM) & is_idle;
    assign stream_xfer = in_valid & in_ready;
    assign start_frame = is_idle & (paced_tick | stream_xfer);

    always_comb begin
        payload = in_data;
        case (mode)
            MODE_COUNT: payload = count_val;
            MODE_FIXED: payload = pattern;
            MODE_LFSR:  payload = lfsr[DATA_BITS-1:0];
            default:    payload = in_data;
        endcase
    end

    // Frame pacing: held at zero whenever pacing is not active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ival_cnt <= '0;
        end else if (!enable || mode == MODE_STRM || ival_tc) begin
            ival_cnt <= '0;
        end else begin
            ival_cnt <= ival_cnt + IVAL_W'(1);
        end
    end

    // Pattern sources advance only on a start taken in their own mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_val <= '0;
            lfsr      <= LFSR_SEED;
        end else if (start_frame) begin
            if (mode == MODE_COUNT) begin
                count_val <= count_val + DATA_BITS'(1);
            end
            if (mode == MODE_LFSR) begin
                lfsr <= lfsr_next(lfsr);
            end
        end
    end

    // Payload shift register and parity: data only, no reset needed
    always_ff @(posedge clk) begin
        if (start_frame) begin
            shreg   <= payload;
            par_bit <= parity_of(payload);
        end else if (baud_tc && (state == S_START || state == S_DATA)) begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= paced_tick & ~is_idle;
            if (!is_idle) begin
                baud_cnt <= baud_tc ? '0 : baud_cnt + BAUD_W'(1);
            end
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                    if (start_frame) begin
                        state <= S_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        state   <= S_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shreg[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        if (bit_cnt == LAST_STOP) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        tx <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pattern_tx.sv
// Directed bench for uart_pattern_tx: four instances cover 8N1, 8E2, 8O1 and a short interval.
module tb_uart_pattern_tx;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] pattern = 8'h00;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       en_a = 1'b0, en_e = 1'b0, en_o = 1'b0, en_v = 1'b0;
    logic       tx_a, busy_a, rdy_a, ov_a;
    logic       tx_e, busy_e, rdy_e, ov_e;
    logic       tx_o, busy_o, rdy_o, ov_o;
    logic       tx_v, busy_v, rdy_v, ov_v;

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;
    logic cur_tx, cur_busy;

    always #5 clk = ~clk;

    always_comb begin
        cur_tx = tx_a;
        cur_busy = busy_a;
        case (sel)
            1: begin cur_tx = tx_e; cur_busy = busy_e; end
            2: begin cur_tx = tx_o; cur_busy = busy_o; end
            3: begin cur_tx = tx_v; cur_busy = busy_v; end
            default: begin cur_tx = tx_a; cur_busy = busy_a; end
        endcase
    end

    uart_pattern_tx #(.BAUD_DIV(BD), .INTERVAL(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .enable(en_a), .mode(mode), .pattern(pattern), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .overrun(ov_a));

    uart_pattern_tx #(.BAUD_DIV(BD), .INTERVAL(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .reset(reset), .enable(en_e), .mode(mode), .pattern(pattern), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_e), .tx(tx_e), .busy(busy_e), .overrun(ov_e));

    uart_pattern_tx #(.BAUD_DIV(BD), .INTERVAL(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .enable(en_o), .mode(mode), .pattern(pattern), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_o), .tx(tx_o), .busy(busy_o), .overrun(ov_o));

    uart_pattern_tx #(.BAUD_DIV(BD), .INTERVAL(30), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_ov (
        .clk(clk), .reset(reset), .enable(en_v), .mode(mode), .pattern(pattern), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_v), .tx(tx_v), .busy(busy_v), .overrun(ov_v));

    // Waits at falling edges for the selected tx to go low; waited = edges passed.
    task automatic wait_fall(input int budget, output int waited, output bit ok);
        waited = 0;
        ok = 1'b0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (cur_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered on the first start-bit cycle; samples every cycle of nbits bit periods.
    task automatic get_frame(input int nbits, output logic [15:0] bits, output bit stable,
                             output int busy_cyc);
        bits = '0;
        stable = 1'b1;
        busy_cyc = 0;
        for (int k = 0; k < nbits * BD; k++) begin
            if (k % BD == 0) bits[k / BD] = cur_tx;
            else if (cur_tx !== bits[k / BD]) stable = 1'b0;
            if (cur_busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        en_a = 0; en_e = 0; en_o = 0; en_v = 0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en_a = 1'b1; mode = 2'b11; in_valid = 1'b1; in_data = 8'h55;
        repeat (2) @(negedge clk);
        vectors++; if (tx_a !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_a); end
        vectors++; if (rdy_a !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", rdy_a); end
        vectors++; if (ov_a !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", ov_a); end
        vectors++;
        if ({tx_e, tx_o, tx_v, busy_e, busy_o, busy_v, rdy_e, rdy_o, rdy_v, ov_e, ov_o, ov_v} !== 12'b111_000_000_000) begin
            miscompares++;
            $display("FAIL reset_others got %b want 111000000000",
                     {tx_e, tx_o, tx_v, busy_e, busy_o, busy_v, rdy_e, rdy_o, rdy_v, ov_e, ov_o, ov_v});
        end
        in_valid = 1'b0; en_a = 1'b0; mode = 2'b00;
    endtask

    task automatic test_counter();
        int w; bit ok; bit st; int bc; logic [15:0] b;
        sel = 0;
        hold_reset();
        mode = 2'b00; en_a = 1'b1;
        reset = 1'b1;
        wait_fall(200, w, ok);
        vectors++; if (!ok || w != 100) begin miscompares++; $display("FAIL cnt_first_start got %0d want 100", w); end
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                wait_fall(100, w, ok);
                vectors++; if (!ok || w + 40 != 100) begin miscompares++; $display("FAIL cnt_period got %0d want 100", w + 40); end
            end
            if (f == 2) en_a = 1'b0;
            get_frame(10, b, st, bc);
            vectors++; if (b[8:1] !== 8'(f)) begin miscompares++; $display("FAIL cnt_byte%0d got %h want %h", f, b[8:1], 8'(f)); end
            vectors++; if ({b[9], b[0]} !== 2'b10) begin miscompares++; $display("FAIL cnt_framing%0d got %b want 10", f, {b[9], b[0]}); end
            vectors++; if (!st) begin miscompares++; $display("FAIL cnt_bit_width%0d got unstable want %0d-clock bits", f, BD); end
            vectors++; if (bc != 40) begin miscompares++; $display("FAIL cnt_busy_len%0d got %0d want 40", f, bc); end
            vectors++; if (cur_busy !== 1'b0) begin miscompares++; $display("FAIL cnt_busy_end%0d got %b want 0", f, cur_busy); end
        end
        wait_fall(150, w, ok);
        vectors++; if (ok) begin miscompares++; $display("FAIL cnt_disabled_start got start after %0d want none", w); end
    endtask

    task automatic test_fixed();
        int w; bit ok; bit st; int bc; logic [15:0] b;
        sel = 1;
        hold_reset();
        mode = 2'b01; pattern = 8'hA5; en_e = 1'b1;
        reset = 1'b1;
        wait_fall(200, w, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL fix_start got timeout want start"); end
        pattern = 8'h3C; mode = 2'b00;
        get_frame(12, b, st, bc);
        vectors++; if (b[11:0] !== 12'hD4A) begin miscompares++; $display("FAIL fix_bits got %h want d4a", b[11:0]); end
        vectors++; if (!st) begin miscompares++; $display("FAIL fix_bit_width got unstable want %0d-clock bits", BD); end
        vectors++; if (bc != 48) begin miscompares++; $display("FAIL fix_busy_len got %0d want 48", bc); end
        vectors++; if (cur_busy !== 1'b0) begin miscompares++; $display("FAIL fix_busy_end got %b want 0", cur_busy); end
        en_e = 1'b0;
    endtask

    task automatic test_lfsr();
        int w; bit ok; bit st; int bc; logic [15:0] b;
        sel = 2;
        hold_reset();
        mode = 2'b10; en_o = 1'b1;
        reset = 1'b1;
        wait_fall(200, w, ok);
        get_frame(11, b, st, bc);
        vectors++; if (!ok || b[10:0] !== {1'b1, 1'b1, 8'hE1, 1'b0}) begin miscompares++; $display("FAIL lfsr_frame1 got %h want %h", b[10:0], {1'b1, 1'b1, 8'hE1, 1'b0}); end
        wait_fall(100, w, ok);
        get_frame(11, b, st, bc);
        vectors++; if (!ok || b[10:0] !== {1'b1, 1'b0, 8'h70, 1'b0}) begin miscompares++; $display("FAIL lfsr_frame2 got %h want %h", b[10:0], {1'b1, 1'b0, 8'h70, 1'b0}); end
        vectors++; if (!st || bc != 44) begin miscompares++; $display("FAIL lfsr_timing got busy %0d stable %0d want 44 1", bc, st); end
        en_o = 1'b0;
    endtask

    task automatic test_overrun();
        logic txs [0:199];
        logic ovs [0:199];
        int n_ov; logic [7:0] d;
        sel = 3;
        hold_reset();
        mode = 2'b00; en_v = 1'b1;
        reset = 1'b1;
        for (int k = 1; k < 190; k++) begin
            @(negedge clk);
            txs[k] = tx_v;
            ovs[k] = ov_v;
        end
        n_ov = 0;
        for (int k = 1; k < 190; k++) if (ovs[k] === 1'b1) n_ov++;
        vectors++; if (n_ov != 3) begin miscompares++; $display("FAIL ovr_count got %0d want 3", n_ov); end
        vectors++; if ({ovs[60], ovs[120], ovs[180]} !== 3'b111) begin miscompares++; $display("FAIL ovr_position got %b want 111", {ovs[60], ovs[120], ovs[180]}); end
        for (int j = 0; j < 3; j++) begin
            int base;
            base = 30 + 60 * j;
            for (int i = 0; i < 8; i++) d[i] = txs[base + BD * (i + 1)];
            vectors++; if (d !== 8'(j)) begin miscompares++; $display("FAIL ovr_byte%0d got %h want %h", j, d, 8'(j)); end
            vectors++;
            if ({txs[base - 1], txs[base], txs[base + 3], txs[base + 36], txs[base + 39]} !== 5'b10011) begin
                miscompares++;
                $display("FAIL ovr_framing%0d got %b want 10011", j,
                         {txs[base - 1], txs[base], txs[base + 3], txs[base + 36], txs[base + 39]});
            end
        end
        en_v = 1'b0;
    endtask

    task automatic test_stream();
        logic txs [0:99];
        logic rdys [0:99];
        int n_rdy; logic [7:0] d;
        sel = 0;
        hold_reset();
        mode = 2'b11; en_a = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        reset = 1'b1;
        #1;
        vectors++; if (rdy_a !== 1'b1) begin miscompares++; $display("FAIL strm_ready0 got %b want 1", rdy_a); end
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            txs[k] = tx_a;
            rdys[k] = rdy_a;
            if (k == 1) in_data = 8'h22;
            if (k == 82) in_valid = 1'b0;
        end
        n_rdy = 0;
        for (int k = 1; k <= 81; k++) if (rdys[k] === 1'b1) n_rdy++;
        vectors++; if (n_rdy != 1 || rdys[41] !== 1'b1 || rdys[82] !== 1'b1) begin miscompares++; $display("FAIL strm_ready got count %0d at41 %b at82 %b want 1 1 1", n_rdy, rdys[41], rdys[82]); end
        for (int i = 0; i < 8; i++) d[i] = txs[1 + BD * (i + 1)];
        vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL strm_byte1 got %h want 11", d); end
        for (int i = 0; i < 8; i++) d[i] = txs[42 + BD * (i + 1)];
        vectors++; if (d !== 8'h22) begin miscompares++; $display("FAIL strm_byte2 got %h want 22", d); end
        vectors++;
        if ({txs[1], txs[37], txs[40], txs[41], txs[42], txs[78], txs[81]} !== 7'b0111011) begin
            miscompares++;
            $display("FAIL strm_gap got %b want 0111011", {txs[1], txs[37], txs[40], txs[41], txs[42], txs[78], txs[81]});
        end
        en_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w; bit ok; bit st; int bc; logic [15:0] b;
        sel = 0;
        hold_reset();
        mode = 2'b00; en_a = 1'b1;
        reset = 1'b1;
        wait_fall(200, w, ok);
        repeat (13) @(negedge clk);
        vectors++; if (!ok || busy_a !== 1'b1) begin miscompares++; $display("FAIL rmid_inframe got busy %b want 1", busy_a); end
        #1 reset = 1'b0;
        #1;
        vectors++; if ({tx_a, busy_a} !== 2'b10) begin miscompares++; $display("FAIL rmid_async got tx,busy %b want 10", {tx_a, busy_a}); end
        @(negedge clk);
        reset = 1'b1;
        wait_fall(200, w, ok);
        get_frame(10, b, st, bc);
        vectors++; if (!ok || w != 100 || b[9:0] !== 10'h200) begin miscompares++; $display("FAIL rmid_restart got wait %0d frame %h want 100 200", w, b[9:0]); end
        en_a = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_counter();
        test_fixed();
        test_lfsr();
        test_overrun();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
